// File: rtl/fanout_rv_fifo.sv
// Registered ready/valid FIFO that forks each buffered word to every active sink.
// FANOUT_EAGER_FORK_EN selects eager per-sink acceptance tracking; undefined builds the lazy fork.
module fanout_rv_fifo #(
  parameter int DATA_WIDTH = 17,
  parameter int NUM_SINKS  = 7,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_SINKS-1:0]    sink_en,
  input  logic [NUM_SINKS-1:0]    sink_sel,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [NUM_SINKS-1:0]    out_valid,
  input  logic [NUM_SINKS-1:0]    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [NUM_SINKS-1:0]  w_active;
  logic                  w_nonempty;
  logic                  w_push;
  logic                  w_pop;

  assign w_active   = sink_en & sink_sel;
  assign w_nonempty = (r_count != '0);

  // in_ready is purely a function of occupancy: a full FIFO never accepts on a pop cycle.
  assign in_ready = (r_count != FULL);
  assign w_push   = in_valid & in_ready;
  assign out_data = r_mem[r_rd_ptr];
  assign count    = r_count;

`ifdef FANOUT_EAGER_FORK_EN
  logic [NUM_SINKS-1:0] r_taken;
  logic [NUM_SINKS-1:0] w_accept;
  logic [NUM_SINKS-1:0] w_done;

  assign out_valid = {NUM_SINKS{w_nonempty}} & w_active & ~r_taken;
  assign w_accept  = out_valid & out_ready;
  // Inactive sinks count as done, so a word with no consumers drains immediately.
  assign w_done    = ~w_active | r_taken | w_accept;
  assign w_pop     = w_nonempty & (&w_done);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_taken <= '0;
    end else if (w_pop) begin
      r_taken <= '0;
    end else begin
      r_taken <= r_taken | w_accept;
    end
  end
`else
  logic w_all_rdy;

  assign w_all_rdy = &(~w_active | out_ready);
  assign out_valid = {NUM_SINKS{w_nonempty & w_all_rdy}} & w_active;
  assign w_pop     = w_nonempty & w_all_rdy;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fanout_rv_fifo.sv
// Self-checking bench for fanout_rv_fifo: queue-based reference model plus directed and random scenarios.
module tb_fanout_rv_fifo;

  localparam int DW    = 17;
  localparam int NS    = 7;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NS-1:0] sink_en;
  logic [NS-1:0] sink_sel;
  logic [DW-1:0] out_data;
  logic [NS-1:0] out_valid;
  logic [NS-1:0] out_ready;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fanout_rv_fifo #(
    .DATA_WIDTH(DW),
    .NUM_SINKS (NS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sink_en  (sink_en),
    .sink_sel (sink_sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the FIFO is a queue of words, each sink remembers whether it already took the head.
  logic [DW-1:0] mq [$];
  logic [NS-1:0] mtaken = '0;
  logic [NS-1:0] exp_valid;
  logic [NS-1:0] m_acc;
  logic          exp_ready;
  logic          m_push;
  logic          m_pop;
  logic [CW-1:0] exp_count;
  logic [DW-1:0] exp_data;

  logic [DW-1:0] dut_rx [NS][$];

  task automatic model_eval();
    logic [NS-1:0] act;
    bit ne;
    bit all;
    act       = sink_en & sink_sel;
    ne        = (mq.size() > 0);
    exp_ready = (mq.size() < DEPTH);
    exp_count = CW'(mq.size());
    exp_data  = ne ? mq[0] : '0;
    all       = 1'b1;
`ifdef FANOUT_EAGER_FORK_EN
    for (int i = 0; i < NS; i++) begin
      exp_valid[i] = ne && act[i] && !mtaken[i];
      if (act[i] && !mtaken[i] && !(exp_valid[i] && out_ready[i])) all = 1'b0;
    end
`else
    for (int i = 0; i < NS; i++) begin
      if (act[i] && !out_ready[i]) all = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      exp_valid[i] = ne && act[i] && all;
    end
`endif
    m_acc  = exp_valid & out_ready;
    m_pop  = ne && all;
    m_push = in_valid && exp_ready;
  endtask

  task automatic model_advance();
    logic [DW-1:0] d;
    if (!rst_n) begin
      mq.delete();
      mtaken = '0;
    end else begin
      if (m_pop) begin
        d = mq.pop_front();
        mtaken = '0;
      end else begin
        mtaken = mtaken | m_acc;
      end
      if (m_push) mq.push_back(in_data);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NS; i++) begin
      if (out_valid[i] && out_ready[i]) dut_rx[i].push_back(out_data);
    end
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_rx();
    for (int i = 0; i < NS; i++) dut_rx[i].delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid  = 1'($urandom);
      in_data   = DW'($urandom);
      sink_en   = NS'($urandom);
      sink_sel  = NS'($urandom);
      out_ready = NS'($urandom);
      #1; model_eval();
      tick();
    end
    rst_n = 1'b1; in_valid = 1'b0; sink_en = '0; sink_sel = '0; out_ready = '0;
    #1; model_eval();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== '0 || count !== '0) begin
      miscompares++;
      $display("FAIL reset: in_ready/out_valid/count got %b/%b/%0d exp 1/0000000/0", in_ready, out_valid, count);
    end
    vectors++;
    if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
      miscompares++;
      $display("FAIL reset_model: got %b/%b/%0d exp %b/%b/%0d", out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
    end
    tick();
  endtask

  task automatic test_single();
    clear_rx();
    sink_en = 7'b0001001; sink_sel = '1; out_ready = '1; in_data = 17'h00005;
    for (int c = 0; c < 3; c++) begin
      in_valid = (c == 0);
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL single c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      if (exp_count != 0) begin
        vectors++;
        if (out_data !== exp_data) begin
          miscompares++;
          $display("FAIL single_data c%0d: got %h exp %h", c, out_data, exp_data);
        end
      end
      if (c == 1) begin
        vectors++;
        if (out_valid !== 7'b0001001 || out_data !== 17'h00005) begin
          miscompares++;
          $display("FAIL single_present: valid/data got %b/%h exp 0001001/00005", out_valid, out_data);
        end
      end
      tick();
    end
    vectors++;
    if (count !== '0 || dut_rx[0].size() != 1 || dut_rx[3].size() != 1) begin
      miscompares++;
      $display("FAIL single_done: count %0d rx0 %0d rx3 %0d exp 0/1/1", count, dut_rx[0].size(), dut_rx[3].size());
    end
  endtask

  task automatic test_skew();
    clear_rx();
    sink_en = 7'b0000011; sink_sel = '1; in_data = 17'h00011;
    for (int c = 0; c < 8; c++) begin
      in_valid  = (c == 0);
      out_ready = {5'b0, (c >= 4), 1'b1};
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL skew c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      if (exp_count != 0) begin
        vectors++;
        if (out_data !== exp_data) begin
          miscompares++;
          $display("FAIL skew_data c%0d: got %h exp %h", c, out_data, exp_data);
        end
      end
      tick();
    end
    vectors++;
    if (dut_rx[0].size() != 1 || dut_rx[1].size() != 1 || count !== '0) begin
      miscompares++;
      $display("FAIL skew_transfers: rx0 %0d rx1 %0d count %0d exp 1/1/0", dut_rx[0].size(), dut_rx[1].size(), count);
    end else begin
      vectors++;
      if (dut_rx[0][0] !== 17'h00011 || dut_rx[1][0] !== 17'h00011) begin
        miscompares++;
        $display("FAIL skew_word: got %h/%h exp 00011", dut_rx[0][0], dut_rx[1][0]);
      end
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] src [$];
    logic [DW-1:0] d;
    clear_rx();
    src = {17'h0000A, 17'h0000B, 17'h0000C};
    sink_en = '1; sink_sel = '1;
    for (int c = 0; c < 16; c++) begin
      in_valid  = (src.size() != 0);
      in_data   = (src.size() != 0) ? src[0] : '0;
      out_ready = (c >= 5) ? '1 : '0;
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL fill c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      if (exp_count != 0) begin
        vectors++;
        if (out_data !== exp_data) begin
          miscompares++;
          $display("FAIL fill_data c%0d: got %h exp %h", c, out_data, exp_data);
        end
      end
      if (c == 3) begin
        vectors++;
        if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
          miscompares++;
          $display("FAIL fill_full: in_ready/count got %b/%0d exp 0/%0d", in_ready, count, DEPTH);
        end
      end
      if (in_valid && exp_ready) d = src.pop_front();
      tick();
    end
    vectors++;
    if (dut_rx[0].size() != 3) begin
      miscompares++;
      $display("FAIL fill_order: got %0d words exp 3", dut_rx[0].size());
    end else begin
      vectors++;
      if (dut_rx[0][0] !== 17'h0000A || dut_rx[0][1] !== 17'h0000B || dut_rx[0][2] !== 17'h0000C) begin
        miscompares++;
        $display("FAIL fill_order: got %h %h %h exp 0000a 0000b 0000c", dut_rx[0][0], dut_rx[0][1], dut_rx[0][2]);
      end
    end
  endtask

  task automatic test_no_sinks();
    int n;
    clear_rx();
    sink_en = '0; sink_sel = NS'($urandom);
    for (int c = 0; c < 8; c++) begin
      in_valid  = (c < 3);
      in_data   = DW'($urandom);
      out_ready = NS'($urandom);
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL nosink c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      tick();
    end
    n = 0;
    for (int i = 0; i < NS; i++) n += dut_rx[i].size();
    vectors++;
    if (count !== '0 || n != 0) begin
      miscompares++;
      $display("FAIL nosink_drain: count %0d transfers %0d exp 0/0", count, n);
    end
  endtask

  task automatic test_reset_mid_fork();
    clear_rx();
    sink_en = 7'b0000101; sink_sel = '1;
    for (int c = 0; c < 7; c++) begin
      rst_n     = (c != 2);
      in_valid  = (c == 0) || (c == 3);
      in_data   = (c == 0) ? 17'h00007 : 17'h00009;
      out_ready = (c == 1) ? 7'b0000001 : (c >= 3) ? 7'b0000101 : 7'b0000000;
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL midreset c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      if (exp_count != 0) begin
        vectors++;
        if (out_data !== exp_data) begin
          miscompares++;
          $display("FAIL midreset_data c%0d: got %h exp %h", c, out_data, exp_data);
        end
      end
      if (c == 3) begin
        vectors++;
        if (count !== '0 || out_valid !== '0) begin
          miscompares++;
          $display("FAIL midreset_clear: count/valid got %0d/%b exp 0/0000000", count, out_valid);
        end
      end
      if (c == 4) begin
        vectors++;
        if (out_valid !== 7'b0000101 || out_data !== 17'h00009) begin
          miscompares++;
          $display("FAIL midreset_next: valid/data got %b/%h exp 0000101/00009", out_valid, out_data);
        end
      end
      tick();
    end
    vectors++;
    if (dut_rx[2].size() != 1 || dut_rx[0].size() == 0) begin
      miscompares++;
      $display("FAIL midreset_rx: rx2 %0d rx0 %0d exp 1/>0", dut_rx[2].size(), dut_rx[0].size());
    end else begin
      vectors++;
      if (dut_rx[2][0] !== 17'h00009 || dut_rx[0][dut_rx[0].size()-1] !== 17'h00009) begin
        miscompares++;
        $display("FAIL midreset_word: got %h/%h exp 00009", dut_rx[0][dut_rx[0].size()-1], dut_rx[2][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int last;
    int next;
    clear_rx();
    first = -1; last = -1; next = 0;
    sink_en = '1; sink_sel = '1; out_ready = '1;
    for (int c = 0; c < 110; c++) begin
      in_valid = (next < 100);
      in_data  = DW'(next);
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL stream c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      if (out_valid[0]) begin
        if (first < 0) first = c;
        last = c;
      end
      if (in_valid && exp_ready) next++;
      tick();
    end
    vectors++;
    if (last - first != 99) begin
      miscompares++;
      $display("FAIL stream_gaps: output span %0d cycles exp 100", last - first + 1);
    end
    for (int i = 0; i < NS; i++) begin
      vectors++;
      if (dut_rx[i].size() != 100) begin
        miscompares++;
        $display("FAIL stream_count sink%0d: got %0d words exp 100", i, dut_rx[i].size());
      end else begin
        for (int k = 0; k < 100; k++) begin
          if (dut_rx[i][k] !== DW'(k)) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_order sink%0d idx %0d: got %h exp %h", i, k, dut_rx[i][k], DW'(k));
            break;
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      in_valid  = 1'($urandom);
      in_data   = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        sink_en  = NS'($urandom);
        sink_sel = NS'($urandom);
      end
      out_ready = NS'($urandom) | NS'($urandom);
      #1; model_eval();
      vectors++;
      if ({out_valid, in_ready, count} !== {exp_valid, exp_ready, exp_count}) begin
        miscompares++;
        $display("FAIL random c%0d: valid/in_ready/count got %b/%b/%0d exp %b/%b/%0d", c, out_valid, in_ready, count, exp_valid, exp_ready, exp_count);
      end
      if (exp_count != 0) begin
        vectors++;
        if (out_data !== exp_data) begin
          miscompares++;
          $display("FAIL random_data c%0d: got %h exp %h", c, out_data, exp_data);
        end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    sink_en = '0; sink_sel = '0; out_ready = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_skew();
    test_fill();
    test_no_sinks();
    test_reset_mid_fork();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fanout_rv_fifo.md
# fanout_rv_fifo

Registered ready/valid FIFO that buffers one incoming stream and forks each word to up to NUM_SINKS configured consumers. It sits directly downstream of the fanout ready-combine logic in a switch-box/routing track. It tracks per-sink acceptance so a word retires only once every active sink has taken it. Slow sinks therefore never cause duplicate or dropped words.

## Interface
Parameters:
- DATA_WIDTH, 17, payload width (16 data + 1 control bit)
- NUM_SINKS, 7, number of fork outputs
- DEPTH, 2, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- in_data  in  DATA_WIDTH  upstream payload
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- sink_en  in  NUM_SINKS  per-sink enable (config)
- sink_sel  in  NUM_SINKS  per-sink route-select bit, already extracted from the config word
- out_data  out  DATA_WIDTH  head payload, shared by all sinks
- out_valid  out  NUM_SINKS  per-sink valid
- out_ready  in  NUM_SINKS  per-sink ready
- count  out  $clog2(DEPTH)+1  occupancy, for debug/perf counters

## Operation
- Active mask: a[i] = sink_en[i] & sink_sel[i]. It is evaluated every cycle, and config changes take effect immediately.
- Push: in_valid & in_ready writes in_data at wr_ptr, then increments wr_ptr modulo DEPTH.
- in_ready = (count != DEPTH). There is no combinational path from out_ready to in_ready, so a full FIFO does not accept a word in the same cycle as a pop.
- Per-sink taken[i] register, eager mode:
  - out_valid[i] = (count != 0) & a[i] & ~taken[i].
  - done[i] = ~a[i] | taken[i] | (out_valid[i] & out_ready[i]).
  - Pop when count != 0 and AND(done) = 1. On pop, rd_ptr increments and all taken bits clear.
  - Without pop, taken[i] is set by out_valid[i] & out_ready[i].
- No active sinks with FIFO non-empty: AND(done) = 1, so words drain and are discarded at one per cycle.
- A sink deactivated while its taken bit is set: the bit is ignored (masked by ~a[i]) and clears on the next pop.
- A sink activated mid-word with taken = 0: it receives the current head.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- out_data = mem[rd_ptr]; it holds its value while the head is not popped.
- Reset (synchronous, any state, including mid-fork):
  - count = 0, wr_ptr = rd_ptr = 0, taken = 0.
  - Buffered words are discarded; memory contents need no reset.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0. out_data is don't-care until the first push.
- Latency: a word pushed in cycle N is presented on out_valid in cycle N+1 at the earliest.
- Throughput: one word per cycle when all active sinks are ready.
- Eager mode: out_valid[i] depends only on registered state and the config inputs, never on out_ready.
- Full: in_ready deasserts in the cycle after count reaches DEPTH, and reasserts in the cycle after the pop.
- Empty: out_valid = 0 for all sinks. out_ready is ignored.

## Configuration
- Macro FANOUT_EAGER_FORK_EN.
- Defined: eager fork with per-sink taken tracking, as described in Operation.
- Undefined: lazy fork.
  - No taken registers are built.
  - all_rdy = AND over j of (~a[j] | out_ready[j]).
  - out_valid[i] = (count != 0) & a[i] & all_rdy.
  - Pop when count != 0 & all_rdy.
  - out_valid now depends combinationally on the out_ready of every active sink, so sinks must not derive out_ready from out_valid.
- Latency, reset values and FIFO behaviour are the same in both builds.

## Test plan
- Reset, then push 0x00005 with sinks 0, 3 active and all ready → cycle N+1: out_valid = 0b0001001, out_data = 0x00005; word popped; count returns to 0.
- Eager fork skew: sinks 0, 1 active, sink 1 ready only 3 cycles later → sink 0 sees exactly one transfer; out_valid[0] drops after its accept; pop occurs in the cycle sink 1 accepts.
- Fill: DEPTH = 2, all sink out_ready = 0, push 0xA, 0xB, 0xC → in_ready = 0 after 2 pushes, 0xC held upstream; after one pop, 0xC is accepted; output order is 0xA, 0xB, 0xC.
- No active sinks (sink_en = 0), push 3 words → all drain at one per cycle; count returns to 0; out_valid stays 0.
- Reset mid-fork: sink 0 has taken word 0x7, sink 2 has not, rst_n = 0 for one cycle → count = 0, out_valid = 0, taken = 0; the next pushed word 0x9 goes to both sinks.
- Continuous streaming: 100 incrementing words, all 7 sinks active and always ready → one word per cycle, no gaps after the first output, each sink receives exactly 0 through 99 in order.
